// File: rtl/ofdm_pkg.sv
// Shared OFDM constants and QPSK bin-to-bit mapping used by both the transmit mapper and the
// receive demapper, so the two sides agree on bit ordering within a byte.
package ofdm_pkg;

  localparam int unsigned WORD_SIZE     = 16;
  localparam int unsigned FFT_POINTS    = 32;
  localparam int unsigned DATA_LENGTH   = 8;
  localparam int unsigned BITS_PER_BIN  = 2;
  localparam int unsigned BINS_PER_BYTE = DATA_LENGTH / BITS_PER_BIN;

  typedef logic [BITS_PER_BIN-1:0] dibit_t;

  // Lowest byte bit position carried by bin k; bin k fills bits [pos+1:pos].
  function automatic int unsigned bin_bit_pos(input int unsigned k);
    return (k % BINS_PER_BYTE) * BITS_PER_BIN;
  endfunction

  // Imaginary decision sits above the real decision within the dibit.
  function automatic dibit_t qpsk_slice(input logic re_nonneg, input logic im_nonneg);
    return {im_nonneg, re_nonneg};
  endfunction

endpackage

// File: rtl/ofdm_byte_fifo.sv
// First-word-fall-through byte FIFO with occupancy output; the head entry is presented on
// o_data whenever o_valid is high, and o_data reads zero while empty.
module ofdm_byte_fifo #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned DATA_LENGTH = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_push,
  input  logic [DATA_LENGTH-1:0]        i_data,
  input  logic                          i_pop,
  output logic [DATA_LENGTH-1:0]        o_data,
  output logic                          o_valid,
  output logic [$clog2(FIFO_DEPTH):0]   o_count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [PtrW:0] Full = (PtrW + 1)'(FIFO_DEPTH);

  logic [DATA_LENGTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]          count_q, count_d;
  logic                   push_ok, pop_ok;

  always_comb begin
    push_ok  = i_push && (count_q != Full);
    pop_ok   = i_pop && (count_q != '0);
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only observable once written.
  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  always_comb begin
    o_valid = (count_q != '0);
    o_data  = o_valid ? mem_q[rd_ptr_q] : '0;
    o_count = count_q;
  end

endmodule

// File: rtl/ofdm_qpsk_demapper.sv
// QPSK hard-decision demapper: slices FFT bins into dibits, packs four bins per byte, checks
// symbol framing against i_bin_last and queues recovered bytes in a FWFT FIFO.
module ofdm_qpsk_demapper #(
  parameter int unsigned WORD_SIZE   = ofdm_pkg::WORD_SIZE,
  parameter int unsigned FFT_POINTS  = ofdm_pkg::FFT_POINTS,
  parameter int unsigned DATA_LENGTH = ofdm_pkg::DATA_LENGTH,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_bin_valid,
  input  logic [WORD_SIZE-1:0]   i_re,
  input  logic [WORD_SIZE-1:0]   i_im,
  input  logic                   i_bin_last,
  output logic                   o_bin_ready,
  output logic [DATA_LENGTH-1:0] o_byte,
  output logic                   o_byte_valid,
  input  logic                   i_byte_ready,
  output logic                   o_sym_done,
  output logic                   o_frame_err
);

  import ofdm_pkg::*;

  localparam int unsigned CntW = $clog2(FFT_POINTS);
  localparam int unsigned FcW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CntW-1:0] LastIdx  = CntW'(FFT_POINTS - 1);
  localparam logic [FcW-1:0]  FifoFull = FcW'(FIFO_DEPTH);
  localparam logic signed [WORD_SIZE-1:0] Zero = '0;

  logic [CntW-1:0]        bin_cnt_q, bin_cnt_d;
  logic [DATA_LENGTH-1:0] asm_q, asm_d, asm_full;
  logic                   sym_done_q, sym_done_d;
  logic                   frame_err_q, frame_err_d;
  logic [FcW-1:0]         fifo_count;
  logic                   accept, at_last, misframed, byte_complete, push;
  dibit_t                 dibit;

  assign o_bin_ready = (fifo_count < FifoFull);

  always_comb begin
    accept        = i_bin_valid && o_bin_ready;
    at_last       = (bin_cnt_q == LastIdx);
    misframed     = (i_bin_last != at_last);
    byte_complete = (bin_bit_pos(32'(bin_cnt_q)) == DATA_LENGTH - BITS_PER_BIN);
    dibit         = qpsk_slice(($signed(i_re) >= Zero), ($signed(i_im) >= Zero));

    asm_full = asm_q;
    asm_full[bin_bit_pos(32'(bin_cnt_q)) +: BITS_PER_BIN] = dibit;

    // A misframed bin never completes a byte, even when it lands on the last dibit slot.
    push = accept && byte_complete && !misframed;

    bin_cnt_d   = bin_cnt_q;
    asm_d       = asm_q;
    sym_done_d  = 1'b0;
    frame_err_d = 1'b0;
    if (accept) begin
      if (misframed) begin
        bin_cnt_d   = '0;
        asm_d       = '0;
        frame_err_d = 1'b1;
      end else begin
        bin_cnt_d  = bin_cnt_q + 1'b1;
        asm_d      = byte_complete ? '0 : asm_full;
        sym_done_d = at_last;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bin_cnt_q   <= '0;
      asm_q       <= '0;
      sym_done_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      bin_cnt_q   <= bin_cnt_d;
      asm_q       <= asm_d;
      sym_done_q  <= sym_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  ofdm_byte_fifo #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .DATA_LENGTH (DATA_LENGTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push),
    .i_data  (asm_full),
    .i_pop   (i_byte_ready),
    .o_data  (o_byte),
    .o_valid (o_byte_valid),
    .o_count (fifo_count)
  );

  assign o_sym_done  = sym_done_q;
  assign o_frame_err = frame_err_q;

endmodule

// File: doc/ofdm_qpsk_demapper.md
OFDM_QPSK_DEMAPPER -- requirements
Module: ofdm_qpsk_demapper

Interface
REQ-001 Parameter WORD_SIZE, default 16: width of each signed two's-complement bin component.
REQ-002 Parameter FFT_POINTS, default 32: bins per OFDM symbol (power of two, at least 4).
REQ-003 Parameter DATA_LENGTH, default 8: output byte width (fixed at 8; 4 QPSK bins per byte).
REQ-004 Parameter FIFO_DEPTH, default 8: output byte FIFO entries (power of two).
REQ-005 i_clk  in  1  single clock; all logic rising-edge.
REQ-006 i_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 i_bin_valid  in  1  bin present on i_re/i_im.
REQ-008 i_re  in  WORD_SIZE  signed real part of current FFT bin.
REQ-009 i_im  in  WORD_SIZE  signed imaginary part of current FFT bin.
REQ-010 i_bin_last  in  1  marks final bin of symbol.
REQ-011 o_bin_ready  out  1  demapper accepts a bin this cycle.
REQ-012 o_byte  out  DATA_LENGTH  recovered data byte (FIFO head).
REQ-013 o_byte_valid  out  1  o_byte holds valid data.
REQ-014 i_byte_ready  in  1  sink consumes o_byte this cycle.
REQ-015 o_sym_done  out  1  one-cycle pulse: well-formed symbol fully accepted.
REQ-016 o_frame_err  out  1  one-cycle pulse: i_bin_last misaligned.

Function
REQ-017 Bin accepted iff i_bin_valid && o_bin_ready at rising edge; o_bin_ready = (fifo_count < FIFO_DEPTH), combinational from registered count.
REQ-018 Hard decision per component: bit = 1 when value >= 0 (sign bit 0), bit = 0 when negative; zero maps to 1.
REQ-019 Bin index k (0..FFT_POINTS-1, counter) contributes bits {im_bit, re_bit} at byte positions [2m+1:2m], m = k mod 4.
REQ-020 On accepting bin with m == 3, assembled byte pushed to FIFO; o_byte_valid asserts the following cycle if FIFO was empty (first-word-fall-through).
REQ-021 Byte popped iff o_byte_valid && i_byte_ready; simultaneous push and pop leaves fifo_count unchanged, any fill level.
REQ-022 o_byte and o_byte_valid stable while o_byte_valid && !i_byte_ready.
REQ-023 Bin counter wraps FFT_POINTS-1 -> 0 on acceptance.
REQ-024 Accepted bin with i_bin_last=1 at k == FFT_POINTS-1: o_sym_done pulses next cycle.
REQ-025 Accepted bin with i_bin_last=1 at k != FFT_POINTS-1, or i_bin_last=0 at k == FFT_POINTS-1: o_frame_err pulses next cycle, partial byte discarded, counter resets to 0; already-pushed bytes kept.
REQ-026 i_bin_last/i_re/i_im ignored when bin not accepted.
REQ-027 Throughput: one bin per cycle sustained when sink always ready; FIFO never overflows or underflows.

Reset
REQ-028 While i_rst_n low: counter=0, assembly reg=0, FIFO empty, o_byte=0, o_byte_valid=0, o_sym_done=0, o_frame_err=0; o_bin_ready=1 after release.
REQ-029 Reset mid-symbol discards partial byte and all FIFO contents; no pulse emitted on release.

Structure
REQ-030 Package ofdm_pkg holds WORD_SIZE, FFT_POINTS, DATA_LENGTH, BITS_PER_BIN=2 constants and bin-to-bit-position mapping, shared with transmit-side mapper.
REQ-031 One sub-module: ofdm_byte_fifo (synchronous FWFT FIFO, parameter FIFO_DEPTH, count output); counter, slicer, framing check in top.

Verification
REQ-032 32 bins re=+256, im=-256, last on bin 31, sink ready -> 8 bytes 0x55, o_sym_done pulse once, no o_frame_err.
REQ-033 Bins alternating (re,im) = (-1,+1),(0,0),(+5,-5),(-7,-7) repeated -> every byte 0x1E (bits m0=10,m1=11,m2=01,m3=00), 8 bytes per symbol.
REQ-034 i_byte_ready=0 for two full symbols -> o_bin_ready drops after 8 bytes queued (bin 31 of symbol 1 accepted), stalls; releasing sink drains 8 bytes in order, then accepts remaining bins.
REQ-035 i_bin_last asserted on bin 9 -> o_frame_err pulse, 2 bytes output, bin-9 partial byte dropped; next 32-bin symbol decodes correctly with o_sym_done.
REQ-036 i_rst_n low for one cycle after bin 17 with FIFO holding 4 bytes -> o_byte_valid=0 immediately, FIFO empty, next symbol yields exactly 8 correct bytes.
REQ-037 Sink toggling ready every cycle with continuous bins -> full-symbol byte sequence matches golden model, no loss or duplication.
